// File: rtl/dcache_miss_controller.sv
// Miss/refill sequencer for a direct-mapped, write-through, no-write-allocate data cache.
// Optional read hit/miss performance counters are enabled by defining DCACHE_PERF_CNT_EN.
module dcache_miss_controller #(
  parameter int WORDS_PER_BLOCK = 4,
  parameter int IDX_W           = 2,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             req_we,
  output logic             ready,
  output logic             adr_en,
  input  logic             hit,
  output logic             out_en,
  output logic             cache_we,
  output logic             mem_sel,
  output logic             valid_clr,
  output logic             valid_set,
  output logic [IDX_W-1:0] word_idx,
  output logic             mem_start,
  output logic             mem_we,
  input  logic             mem_ready,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LATCH   = 4'd1,
    S_LOOKUP  = 4'd2,
    S_RF_REQ  = 4'd3,
    S_RF_WAIT = 4'd4,
    S_RF_WR   = 4'd5,
    S_RD_OUT  = 4'd6,
    S_WR_REQ  = 4'd7,
    S_WR_WAIT = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  state_t           state_r, state_s;
  logic [IDX_W-1:0] word_idx_r, word_idx_s;
  logic             req_we_r;

  // State, refill word index and captured access direction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      word_idx_r <= IDX_ZERO;
      req_we_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      word_idx_r <= word_idx_s;
      if (state_r == S_IDLE && req) begin
        req_we_r <= req_we;
      end else begin
        req_we_r <= req_we_r;
      end
    end
  end

  // Next-state and word index sequencing
  always_comb begin
    state_s    = state_r;
    word_idx_s = word_idx_r;
    case (state_r)
      S_IDLE: begin
        if (req) state_s = S_LATCH;
        else     state_s = S_IDLE;
      end
      S_LATCH: state_s = S_LOOKUP;
      S_LOOKUP: begin
        if (req_we_r) begin
          state_s = S_WR_REQ;
        end else if (hit) begin
          state_s = S_RD_OUT;
        end else begin
          state_s    = S_RF_REQ;
          word_idx_s = IDX_ZERO;
        end
      end
      S_RF_REQ: state_s = S_RF_WAIT;
      S_RF_WAIT: begin
        if (mem_ready) state_s = S_RF_WR;
        else           state_s = S_RF_WAIT;
      end
      S_RF_WR: begin
        if (word_idx_r == LAST_IDX) begin
          word_idx_s = IDX_ZERO;
          state_s    = S_RD_OUT;
        end else begin
          word_idx_s = word_idx_r + IDX_ONE;
          state_s    = S_RF_REQ;
        end
      end
      S_RD_OUT: state_s = S_DONE;
      S_WR_REQ: state_s = S_WR_WAIT;
      S_WR_WAIT: begin
        if (mem_ready) state_s = S_DONE;
        else           state_s = S_WR_WAIT;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Moore output decode; only the write-through cache update looks at hit
  always_comb begin
    ready     = 1'b0;
    adr_en    = 1'b0;
    out_en    = 1'b0;
    cache_we  = 1'b0;
    mem_sel   = 1'b0;
    valid_clr = 1'b0;
    valid_set = 1'b0;
    mem_start = 1'b0;
    mem_we    = 1'b0;
    case (state_r)
      S_LATCH: adr_en = 1'b1;
      S_RF_REQ: begin
        mem_start = 1'b1;
        mem_sel   = 1'b1;
        if (word_idx_r == IDX_ZERO) valid_clr = 1'b1;
        else                        valid_clr = 1'b0;
      end
      S_RF_WR: begin
        cache_we = 1'b1;
        mem_sel  = 1'b1;
        if (word_idx_r == LAST_IDX) valid_set = 1'b1;
        else                        valid_set = 1'b0;
      end
      S_RD_OUT: out_en = 1'b1;
      S_WR_REQ: begin
        mem_start = 1'b1;
        mem_we    = 1'b1;
        if (hit) cache_we = 1'b1;
        else     cache_we = 1'b0;
      end
      S_DONE:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign word_idx = word_idx_r;

`ifdef DCACHE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] hit_cnt_r, miss_cnt_r;

  // Saturating read hit/miss counters, bumped once per read lookup
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_r  <= {CNT_W{1'b0}};
      miss_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == S_LOOKUP && !req_we_r) begin
      if (hit && hit_cnt_r != CNT_MAX)   hit_cnt_r  <= hit_cnt_r + CNT_ONE;
      if (!hit && miss_cnt_r != CNT_MAX) miss_cnt_r <= miss_cnt_r + CNT_ONE;
    end
  end

  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;
`else
  assign hit_cnt  = {CNT_W{1'b0}};
  assign miss_cnt = {CNT_W{1'b0}};
`endif

endmodule
